comp_acc: RTL and testbench
===========================

Name: comp_acc

Overview:
- Complex accumulator that sits directly downstream of the time-multiplexed complex multiplier.
- Consumes one signed complex product (real, imag) per valid strobe and sums N consecutive products per frame with per-component saturation.
- Presents the registered frame sum with a one-cycle valid pulse, for correlator and dot-product use.
- Gaps between strobes are allowed, so the block tracks the multiplier's two-cycle issue rate or any slower rate.

Parameters:
- IN_W, 17, width of the signed input components (matches the multiplier output width).
- ACC_W, 24, width of the signed accumulator and output components; must be at least IN_W.
- N, 8, number of products per frame; must be at least 1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- i_valid  input  1  in_r and in_i hold a valid product this cycle.
- i_clr  input  1  synchronous frame abort and clear.
- in_r  input  IN_W  signed real part of the product.
- in_i  input  IN_W  signed imaginary part of the product.
- o_valid  output  1  one-cycle pulse: o_r, o_i and o_sat carry a new frame result.
- o_r  output  ACC_W  signed real frame sum, registered.
- o_i  output  ACC_W  signed imaginary frame sum, registered.
- o_sat  output  1  at least one component saturated during the frame reported by o_r/o_i.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, acc_r=acc_i=0, cnt=0, sticky sat flag=0; o_r=0, o_i=0, o_sat=0, o_valid=0.
- State machine: IDLE (no sample held in the current frame) and ACC (cnt samples held, 1 <= cnt <= N-1).
- Sample accepted = i_valid=1 and i_clr=0 on a rising edge. Inputs are sign-extended to ACC_W before adding.
- IDLE + accepted sample:
  - acc = sext(in).
  - If N=1, the frame completes immediately.
  - Otherwise cnt=1 and the state moves to ACC.
- ACC + accepted sample:
  - acc = sat(acc + sext(in)) for each component independently.
  - cnt increments.
  - When cnt was N-1 (this is the Nth sample), the frame completes.
- Frame complete, in the same edge:
  - o_r and o_i are loaded with the final saturated sums.
  - o_sat is loaded with (sticky flag OR saturation on this add).
  - o_valid=1 during the following cycle only.
  - acc, cnt and the sticky flag clear; state returns to IDLE.
- Latency: o_valid is asserted in the cycle after the edge that accepts the Nth sample.
- Back-to-back frames: a sample accepted in the cycle where o_valid=1 starts the next frame. There is no bubble.
- Saturation:
  - Exact sum > 2^(ACC_W-1)-1 clamps to 2^(ACC_W-1)-1.
  - Exact sum < -2^(ACC_W-1) clamps to -2^(ACC_W-1).
  - Subsequent adds continue from the clamped value.
  - Any clamp on either component sets the sticky flag.
- o_r, o_i and o_sat hold their value until the next frame completes. They are unaffected by i_clr.
- i_clr=1 has priority over i_valid:
  - The sample presented that cycle is dropped.
  - acc, cnt and the sticky flag clear; state goes to IDLE.
  - o_valid=0 next cycle.
- i_valid=0 with i_clr=0: all state holds.
- Reset mid-frame: the partial frame is discarded; no o_valid is produced for it.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE and ACC;
  - default widths IN_W=17 and ACC_W=24;
  - ACC_MAX and ACC_MIN limit constants, as functions of ACC_W;
  - counter width CNT_W = clog2(N), minimum 1.
- One sub-module, sat_add: combinational ACC_W signed saturating adder with a sat flag output. It is instantiated twice, once for real and once for imaginary.
- Control FSM, counter and output registers live in comp_acc.

Test Plan:
- N=4, ACC_W=24, samples (100,-50), (200,25), (-30,-30), (7,0) with i_valid gaps of 0, 1 and 3 cycles -> one o_valid pulse, one cycle after the 4th sample; o_r=277, o_i=-55, o_sat=0.
- N=4, two frames back-to-back with i_valid held high: frame 1 is all (1,2), frame 2 is all (-3,5) -> o_valid pulses exactly 4 cycles apart; results (4,8) then (-12,20); no sample lost.
- N=4, ACC_W=18:
  - four samples of (65535,-65536) -> o_r=131071, o_i=-131072, o_sat=1.
  - next frame of four (1,1) -> (4,4), o_sat=0.
- N=4: two samples (10,10), then i_clr=1 together with i_valid=1 and (99,99), then four samples (1,-1) -> single o_valid; result (4,-4); (99,99) is ignored.
- N=4: rst pulsed low after two samples -> o_r=o_i=0, o_valid=0; the next four samples (2,3) give (8,12).
- N=1: samples (5,-5) then (-7,7) on consecutive cycles -> o_valid high two cycles running; outputs (5,-5) then (-7,7).

Source files
------------

// File: rtl/comp_acc_pkg.sv
// Shared constants and helpers for the complex frame accumulator.
package comp_acc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_e;

    localparam int unsigned DEF_IN_W  = 17;
    localparam int unsigned DEF_ACC_W = 24;

    // Callers truncate these 64-bit results to their own accumulator width.
    function automatic logic [63:0] acc_max(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] acc_min(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/comp_acc_sat_add.sv
// Combinational signed saturating adder; sat_o flags a clamp.
module sat_add
    import comp_acc_pkg::*;
#(
    parameter int unsigned W = DEF_ACC_W
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] sum_o,
    output logic                sat_o
);

    localparam logic [W-1:0] MaxVal = W'(acc_max(W));
    localparam logic [W-1:0] MinVal = W'(acc_min(W));

    logic signed [W:0] sum_full;

    always_comb begin
        sum_full = {a_i[W-1], a_i} + {b_i[W-1], b_i};
        sat_o    = 1'b0;
        sum_o    = sum_full[W-1:0];
        // The two top bits differ only when the exact sum left the W-bit range.
        if (sum_full[W] != sum_full[W-1]) begin
            sat_o = 1'b1;
            sum_o = sum_full[W] ? MinVal : MaxVal;
        end
    end

endmodule

// File: rtl/comp_acc.sv
// Sums N signed complex products per frame with per-component saturation.
module comp_acc
    import comp_acc_pkg::*;
#(
    parameter int unsigned IN_W  = DEF_IN_W,
    parameter int unsigned ACC_W = DEF_ACC_W,
    parameter int unsigned N     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    input  logic                    i_clr,
    input  logic signed [IN_W-1:0]  in_r,
    input  logic signed [IN_W-1:0]  in_i,
    output logic                    o_valid,
    output logic signed [ACC_W-1:0] o_r,
    output logic signed [ACC_W-1:0] o_i,
    output logic                    o_sat
);

    localparam int unsigned CNT_W = cnt_width(N);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_r_q, acc_r_d, acc_i_q, acc_i_d;
    logic                    sat_q, sat_d;
    logic signed [ACC_W-1:0] o_r_q, o_r_d, o_i_q, o_i_d;
    logic                    o_sat_q, o_sat_d, o_valid_q, o_valid_d;

    logic signed [ACC_W-1:0] ext_r, ext_i, sum_r, sum_i, new_r, new_i;
    logic                    sat_r, sat_i, sat_now;
    logic                    accept, last, frame_done;

    assign ext_r = ACC_W'(in_r);
    assign ext_i = ACC_W'(in_i);

    sat_add #(.W(ACC_W)) u_add_r (
        .a_i   (acc_r_q),
        .b_i   (ext_r),
        .sum_o (sum_r),
        .sat_o (sat_r)
    );

    sat_add #(.W(ACC_W)) u_add_i (
        .a_i   (acc_i_q),
        .b_i   (ext_i),
        .sum_o (sum_i),
        .sat_o (sat_i)
    );

    assign accept     = i_valid & ~i_clr;
    assign last       = (state_q == IDLE) ? (N == 1) : (cnt_q == CNT_W'(N - 1));
    assign frame_done = accept & last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_clr || frame_done) begin
            state_d = IDLE;
        end else if (accept) begin
            state_d = ACC;
        end
    end

    always_comb begin
        // The first sample of a frame loads directly; it can never clamp since ACC_W >= IN_W.
        new_r   = (state_q == IDLE) ? ext_r : sum_r;
        new_i   = (state_q == IDLE) ? ext_i : sum_i;
        sat_now = (state_q == ACC) & (sat_r | sat_i);

        acc_r_d   = acc_r_q;
        acc_i_d   = acc_i_q;
        cnt_d     = cnt_q;
        sat_d     = sat_q;
        o_r_d     = o_r_q;
        o_i_d     = o_i_q;
        o_sat_d   = o_sat_q;
        o_valid_d = frame_done;

        if (i_clr || frame_done) begin
            acc_r_d = '0;
            acc_i_d = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
        end else if (accept) begin
            acc_r_d = new_r;
            acc_i_d = new_i;
            cnt_d   = cnt_q + 1'b1;
            sat_d   = sat_q | sat_now;
        end

        if (frame_done) begin
            o_r_d   = new_r;
            o_i_d   = new_i;
            o_sat_d = sat_q | sat_now;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r_q   <= '0;
            acc_i_q   <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            o_r_q     <= '0;
            o_i_q     <= '0;
            o_sat_q   <= 1'b0;
            o_valid_q <= 1'b0;
        end else begin
            acc_r_q   <= acc_r_d;
            acc_i_q   <= acc_i_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            o_r_q     <= o_r_d;
            o_i_q     <= o_i_d;
            o_sat_q   <= o_sat_d;
            o_valid_q <= o_valid_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_r     = o_r_q;
    assign o_i     = o_i_q;
    assign o_sat   = o_sat_q;

endmodule

// File: tb/tb_comp_acc.sv
// Bench for comp_acc: three instances (N=4/ACC_W=24, N=4/ACC_W=18, N=1) checked via scoreboards.
module tb_comp_acc;

    typedef struct {
        int r;
        int i;
        bit s;
        int cyc;
    } exp_t;

    typedef struct {
        int d;
        int r;
        int i;
        int gap;
        bit clr;
        bit last;
        int er;
        int ei;
        bit es;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic v[3];
    logic c[3];
    logic signed [16:0] xr[3];
    logic signed [16:0] xi[3];
    logic ov[3];
    logic os[3];
    logic signed [23:0] or0, oi0, or2, oi2;
    logic signed [17:0] or1, oi1;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t q[3][$];
    vec_t tbl[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    comp_acc #(.IN_W(17), .ACC_W(24), .N(4)) u_a (
        .clk(clk), .rst(rst), .i_valid(v[0]), .i_clr(c[0]), .in_r(xr[0]), .in_i(xi[0]),
        .o_valid(ov[0]), .o_r(or0), .o_i(oi0), .o_sat(os[0])
    );

    comp_acc #(.IN_W(17), .ACC_W(18), .N(4)) u_b (
        .clk(clk), .rst(rst), .i_valid(v[1]), .i_clr(c[1]), .in_r(xr[1]), .in_i(xi[1]),
        .o_valid(ov[1]), .o_r(or1), .o_i(oi1), .o_sat(os[1])
    );

    comp_acc #(.IN_W(17), .ACC_W(24), .N(1)) u_c (
        .clk(clk), .rst(rst), .i_valid(v[2]), .i_clr(c[2]), .in_r(xr[2]), .in_i(xi[2]),
        .o_valid(ov[2]), .o_r(or2), .o_i(oi2), .o_sat(os[2])
    );

    function automatic void chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endfunction

    function automatic void mon(input int d, input int r, input int i, input bit s);
        exp_t e;
        if (q[d].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid_dut%0d actual=1 expected=0 at cyc %0d", d, cyc);
        end else begin
            e = q[d].pop_front();
            chk($sformatf("o_r_dut%0d", d), r, e.r);
            chk($sformatf("o_i_dut%0d", d), i, e.i);
            chk($sformatf("o_sat_dut%0d", d), int'(s), int'(e.s));
            chk($sformatf("latency_dut%0d", d), cyc, e.cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (ov[0]) mon(0, int'(or0), int'(oi0), os[0]);
            if (ov[1]) mon(1, int'(or1), int'(oi1), os[1]);
            if (ov[2]) mon(2, int'(or2), int'(oi2), os[2]);
        end
    end

    // Called just after a rising edge; holds the sample for one edge then idles for gap cycles.
    task automatic send(input int d, input int r, input int i, input bit clr, input int gap);
        v[d]  = 1'b1;
        c[d]  = clr;
        xr[d] = 17'(r);
        xi[d] = 17'(i);
        @(posedge clk);
        #1;
        v[d] = 1'b0;
        c[d] = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic add(input int d, input int r, input int i, input int gap, input bit clr,
                       input bit last, input int er, input int ei, input bit es);
        vec_t e;
        e.d = d; e.r = r; e.i = i; e.gap = gap; e.clr = clr;
        e.last = last; e.er = er; e.ei = ei; e.es = es;
        tbl.push_back(e);
    endtask

    initial begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            v[d] = 1'b0; c[d] = 1'b0; xr[d] = '0; xi[d] = '0;
        end

        // Gapped frame, then two back-to-back frames with i_valid held high.
        add(0, 100, -50, 0, 0, 0, 0, 0, 0);
        add(0, 200, 25, 1, 0, 0, 0, 0, 0);
        add(0, -30, -30, 3, 0, 0, 0, 0, 0);
        add(0, 7, 0, 2, 0, 1, 277, -55, 0);
        for (int k = 0; k < 4; k++) add(0, 1, 2, 0, 0, k == 3, 4, 8, 0);
        for (int k = 0; k < 4; k++) add(0, -3, 5, 0, 0, k == 3, -12, 20, 0);
        // 18-bit accumulator: both components clamp, then a clean frame clears o_sat.
        for (int k = 0; k < 4; k++) add(1, 65535, -65536, 0, 0, k == 3, 131071, -131072, 1);
        for (int k = 0; k < 4; k++) add(1, 1, 1, 0, 0, k == 3, 4, 4, 0);
        // Abort mid-frame; the sample presented alongside i_clr is dropped.
        add(0, 10, 10, 0, 0, 0, 0, 0, 0);
        add(0, 10, 10, 0, 0, 0, 0, 0, 0);
        add(0, 99, 99, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) add(0, 1, -1, (k == 3) ? 2 : 0, 0, k == 3, 4, -4, 0);
        // N=1: every sample is a frame, consecutive pulses.
        add(2, 5, -5, 0, 0, 1, 5, -5, 0);
        add(2, -7, 7, 2, 0, 1, -7, 7, 0);

        #2;
        chk("reset_o_valid", int'(ov[0]), 0);
        chk("reset_o_r", int'(or0), 0);
        chk("reset_o_i", int'(oi0), 0);
        chk("reset_o_sat", int'(os[0]), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[n]) begin
            if (tbl[n].last) begin
                e.r = tbl[n].er; e.i = tbl[n].ei; e.s = tbl[n].es; e.cyc = cyc + 1;
                q[tbl[n].d].push_back(e);
            end
            send(tbl[n].d, tbl[n].r, tbl[n].i, tbl[n].clr, tbl[n].gap);
        end

        // Asynchronous reset mid-frame discards the partial frame and zeroes outputs.
        send(0, 2, 3, 0, 0);
        send(0, 2, 3, 0, 0);
        rst = 1'b0;
        #2;
        chk("midrst_o_valid", int'(ov[0]), 0);
        chk("midrst_o_r", int'(or0), 0);
        chk("midrst_o_i", int'(oi0), 0);
        chk("midrst_o_sat", int'(os[0]), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                e.r = 8; e.i = 12; e.s = 0; e.cyc = cyc + 1;
                q[0].push_back(e);
            end
            send(0, 2, 3, 0, 0);
        end

        for (int k = 0; k < 50 && (q[0].size() + q[1].size() + q[2].size()) > 0; k++) begin
            @(posedge clk);
        end
        repeat (3) @(posedge clk);
        for (int d = 0; d < 3; d++) chk($sformatf("pending_dut%0d", d), q[d].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule
